// File: rtl/link_list_pkg.sv
// Shared definitions for the linked-list engine: opcodes, status codes,
// controller states and the word layout of a node in RAM.
package link_list_pkg;

    typedef enum logic [1:0] {
        OP_INS = 2'b00,
        OP_DEL = 2'b01,
        OP_WR  = 2'b10,
        OP_RD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_ERR_RANGE = 2'b01,
        ST_ERR_FULL  = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WALK,
        S_EXEC,
        S_RESP
    } state_e;

    // A node is two consecutive words: payload, then next pointer.
    localparam int DATA_OFS = 0;
    localparam int NEXT_OFS = 1;

    localparam int STEP_W = 3;

endpackage

// File: rtl/link_list_init_seq.sv
// Post-reset RAM initialiser: clears the list head words, then chains every
// node's next word into one free list (node k -> node k+1, last -> null).
// Emits one write per cycle while enabled and a single-cycle 'last' on the
// final write.
module link_list_init_seq
    import link_list_pkg::*;
#(
    parameter int LIST_NUM   = 4,
    parameter int NODE_NUM   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  last
);

    localparam int TOTAL = LIST_NUM + NODE_NUM;
    localparam int CW    = $clog2(TOTAL + 1);

    logic [CW-1:0] cnt_q;
    int            c_i;
    int            k_i;

    // Write counter; wraps to zero after the last write so a later reset
    // finds it clean either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (en)
            cnt_q <= last ? '0 : cnt_q + 1'b1;
    end

    // Address/data for the current write: heads first, then node next words.
    always_comb begin
        c_i   = int'(cnt_q);
        k_i   = 0;
        addr  = '0;
        wdata = '0;
        if (c_i < LIST_NUM) begin
            addr = ADDR_WIDTH'(c_i);
        end else begin
            k_i  = c_i - LIST_NUM;
            addr = ADDR_WIDTH'(LIST_NUM + 2 * k_i + NEXT_OFS);
            if (k_i != NODE_NUM - 1)
                wdata = DATA_WIDTH'(LIST_NUM + 2 * (k_i + 1) + DATA_OFS);
        end
        last = en && (cnt_q == CW'(TOTAL - 1));
    end

endmodule

// File: rtl/link_list_engine.sv
// Multi-list linked-list engine over a single-port RAM (1-cycle read latency).
// Head pointers at 0..LIST_NUM-1, node k at LIST_NUM+2k (data) / +1 (next).
// RAM outputs are registered: an access issued in one step is on the bus the
// next cycle and its read data is consumed the cycle after that.
// Optional build macro LINK_LEN_TRACK_EN adds per-list length registers that
// reject out-of-range requests in IDLE and drive rsp_len.
module link_list_engine
    import link_list_pkg::*;
#(
    parameter int LIST_NUM   = 4,
    parameter int NODE_NUM   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_op,
    input  logic [$clog2(LIST_NUM)-1:0] req_list,
    input  logic [IDX_WIDTH-1:0]        req_idx,
    input  logic [DATA_WIDTH-1:0]       req_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [1:0]                  rsp_status,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [IDX_WIDTH-1:0]        rsp_len,
    output logic                        init_done,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic                        ram_we,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    input  logic [DATA_WIDTH-1:0]       ram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] NXT = ADDR_WIDTH'(NEXT_OFS);
    localparam logic [ADDR_WIDTH-1:0] DAT = ADDR_WIDTH'(DATA_OFS);

    state_e                  state_q, state_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [IDX_WIDTH-1:0]    hop_q, hop_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;     // word holding the pointer to node 'hop'
    logic [ADDR_WIDTH-1:0]   free_q, free_d;   // free-list head, 0 = pool empty
    logic [ADDR_WIDTH-1:0]   ta_q, ta_d;       // INS old / DEL victim / target node
    logic [ADDR_WIDTH-1:0]   tb_q, tb_d;       // INS free-next / DEL victim-next
    op_e                     op_q, op_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [1:0]              rsp_status_q, rsp_status_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic                    ram_we_q, ram_we_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    init_done_q, init_done_d;

    logic [ADDR_WIDTH-1:0]   init_addr;
    logic [DATA_WIDTH-1:0]   init_data;
    logic                    init_last;
    logic [ADDR_WIDTH-1:0]   rd_ptr;

`ifdef LINK_LEN_TRACK_EN
    logic [$clog2(LIST_NUM)-1:0]        list_q, list_d;
    logic [LIST_NUM-1:0][IDX_WIDTH-1:0] len_q, len_d;
    logic                               len_err;
`endif

    // Pointers live zero-extended in RAM; only the low address bits matter.
    assign rd_ptr = ram_rdata[ADDR_WIDTH-1:0];

    function automatic logic [DATA_WIDTH-1:0] to_word(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(a);
    endfunction

    link_list_init_seq #(
        .LIST_NUM  (LIST_NUM),
        .NODE_NUM  (NODE_NUM),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_init (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q == S_INIT),
        .addr (init_addr),
        .wdata(init_data),
        .last (init_last)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_status = rsp_status_q;
    assign rsp_data   = rsp_data_q;
    assign init_done  = init_done_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;

`ifdef LINK_LEN_TRACK_EN
    assign len_err = (req_op == OP_INS) ? (req_idx >  len_q[req_list])
                                        : (req_idx >= len_q[req_list]);
    assign rsp_len = len_q[list_q];
`else
    assign rsp_len = '0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            step_q       <= '0;
            hop_q        <= '0;
            ptr_q        <= '0;
            free_q       <= '0;
            ta_q         <= '0;
            tb_q         <= '0;
            op_q         <= OP_INS;
            idx_q        <= '0;
            data_q       <= '0;
            rsp_status_q <= '0;
            rsp_data_q   <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            init_done_q  <= 1'b0;
`ifdef LINK_LEN_TRACK_EN
            list_q       <= '0;
            len_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            hop_q        <= hop_d;
            ptr_q        <= ptr_d;
            free_q       <= free_d;
            ta_q         <= ta_d;
            tb_q         <= tb_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            init_done_q  <= init_done_d;
`ifdef LINK_LEN_TRACK_EN
            list_q       <= list_d;
            len_q        <= len_d;
`endif
        end
    end

    // Next-state and datapath: init, accept, pointer walk, op micro-steps, respond.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        hop_d        = hop_q;
        ptr_d        = ptr_q;
        free_d       = free_q;
        ta_d         = ta_q;
        tb_d         = tb_q;
        op_d         = op_q;
        idx_d        = idx_q;
        data_d       = data_q;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        init_done_d  = init_done_q;
`ifdef LINK_LEN_TRACK_EN
        list_d       = list_q;
        len_d        = len_q;
`endif

        case (state_q)
            S_INIT: begin
                ram_addr_d  = init_addr;
                ram_wdata_d = init_data;
                ram_we_d    = 1'b1;
`ifdef LINK_LEN_TRACK_EN
                len_d       = '0;
`endif
                if (init_last) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    free_d      = ADDR_WIDTH'(LIST_NUM);
                end
            end

            S_IDLE: begin
                if (req_valid) begin
                    op_d   = op_e'(req_op);
                    idx_d  = req_idx;
                    data_d = req_data;
                    ptr_d  = ADDR_WIDTH'(req_list);
                    hop_d  = '0;
                    step_d = '0;
`ifdef LINK_LEN_TRACK_EN
                    list_d = req_list;
`endif
                    if (op_e'(req_op) == OP_INS && free_q == '0) begin
                        state_d      = S_RESP;
                        rsp_status_d = ST_ERR_FULL;
                    end
`ifdef LINK_LEN_TRACK_EN
                    else if (len_err) begin
                        state_d      = S_RESP;
                        rsp_status_d = ST_ERR_RANGE;
                    end
`endif
                    else begin
                        state_d = S_WALK;
                    end
                end
            end

            // Follow 'idx' next pointers; a null before that is out of range.
            S_WALK: begin
                case (step_q)
                    3'd0: begin
                        if (hop_q == idx_q) begin
                            state_d = S_EXEC;
                        end else begin
                            ram_addr_d = ptr_q;
                            step_d     = 3'd1;
                        end
                    end
                    3'd1: step_d = 3'd2;
                    default: begin
                        step_d = 3'd0;
                        if (rd_ptr == '0) begin
                            state_d      = S_RESP;
                            rsp_status_d = ST_ERR_RANGE;
                        end else begin
                            ptr_d = rd_ptr + NXT;
                            hop_d = hop_q + 1'b1;
                        end
                    end
                endcase
            end

            S_EXEC: begin
                step_d = step_q + 1'b1;
                case (op_q)
                    OP_INS: begin
                        case (step_q)
                            3'd0: ram_addr_d = ptr_q;
                            3'd1: ram_addr_d = free_q + NXT;
                            3'd2: begin
                                ta_d        = rd_ptr;
                                ram_addr_d  = free_q + DAT;
                                ram_wdata_d = data_q;
                                ram_we_d    = 1'b1;
                            end
                            3'd3: begin
                                tb_d        = rd_ptr;
                                ram_addr_d  = free_q + NXT;
                                ram_wdata_d = to_word(ta_q);
                                ram_we_d    = 1'b1;
                            end
                            default: begin
                                ram_addr_d   = ptr_q;
                                ram_wdata_d  = to_word(free_q);
                                ram_we_d     = 1'b1;
                                free_d       = tb_q;
                                state_d      = S_RESP;
                                rsp_status_d = ST_OK;
`ifdef LINK_LEN_TRACK_EN
                                len_d[list_q] = len_q[list_q] + 1'b1;
`endif
                            end
                        endcase
                    end

                    OP_DEL: begin
                        case (step_q)
                            3'd0: ram_addr_d = ptr_q;
                            3'd1: ;
                            3'd2: begin
                                ta_d = rd_ptr;
                                if (rd_ptr == '0) begin
                                    state_d      = S_RESP;
                                    rsp_status_d = ST_ERR_RANGE;
                                end else begin
                                    ram_addr_d = rd_ptr + NXT;
                                end
                            end
                            3'd3: ram_addr_d = ta_q + DAT;
                            3'd4: tb_d = rd_ptr;
                            3'd5: begin
                                rsp_data_d  = ram_rdata;
                                ram_addr_d  = ptr_q;
                                ram_wdata_d = to_word(tb_q);
                                ram_we_d    = 1'b1;
                            end
                            default: begin
                                // Victim goes back on top of the free list.
                                ram_addr_d   = ta_q + NXT;
                                ram_wdata_d  = to_word(free_q);
                                ram_we_d     = 1'b1;
                                free_d       = ta_q;
                                state_d      = S_RESP;
                                rsp_status_d = ST_OK;
`ifdef LINK_LEN_TRACK_EN
                                len_d[list_q] = len_q[list_q] - 1'b1;
`endif
                            end
                        endcase
                    end

                    OP_WR: begin
                        case (step_q)
                            3'd0: ram_addr_d = ptr_q;
                            3'd1: ;
                            default: begin
                                state_d = S_RESP;
                                if (rd_ptr == '0) begin
                                    rsp_status_d = ST_ERR_RANGE;
                                end else begin
                                    ram_addr_d   = rd_ptr + DAT;
                                    ram_wdata_d  = data_q;
                                    ram_we_d     = 1'b1;
                                    rsp_status_d = ST_OK;
                                end
                            end
                        endcase
                    end

                    default: begin  // OP_RD
                        case (step_q)
                            3'd0: ram_addr_d = ptr_q;
                            3'd1: ;
                            3'd2: begin
                                if (rd_ptr == '0) begin
                                    state_d      = S_RESP;
                                    rsp_status_d = ST_ERR_RANGE;
                                end else begin
                                    ram_addr_d = rd_ptr + DAT;
                                end
                            end
                            3'd3: ;
                            default: begin
                                rsp_data_d   = ram_rdata;
                                state_d      = S_RESP;
                                rsp_status_d = ST_OK;
                            end
                        endcase
                    end
                endcase
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d      = S_IDLE;
                    rsp_status_d = '0;
                    rsp_data_d   = '0;
                end
            end

            default: state_d = S_INIT;
        endcase
    end

endmodule
